// File: rtl/mmio_port.sv
// Memory-mapped peripheral responder: LED/display registers, millisecond timer
// with compare, synchronized buttons with sticky edge flags and a level interrupt.
module mmio_port #(
  parameter int unsigned CYCLES_PER_MS = 50000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sel,
  input  logic [14:0] address,
  input  logic [15:0] data_in,
  input  logic        we,
  output logic [15:0] data_out,
  output logic [3:0]  leds,
  output logic [15:0] display_value,
  input  logic [3:0]  btn,
  output logic        irq
);

  localparam int unsigned PW = (CYCLES_PER_MS > 2) ? $clog2(CYCLES_PER_MS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CYCLES_PER_MS - 1);
  localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
  localparam logic [PW-1:0] PRESC_ZERO = PW'(0);

  localparam logic [2:0] A_LED     = 3'd0;
  localparam logic [2:0] A_DISPLAY = 3'd1;
  localparam logic [2:0] A_COUNT   = 3'd2;
  localparam logic [2:0] A_COMPARE = 3'd3;
  localparam logic [2:0] A_STATUS  = 3'd4;
  localparam logic [2:0] A_BUTTONS = 3'd5;
  localparam logic [2:0] A_MASK    = 3'd6;

  logic [3:0]    led_q,      led_d;
  logic [15:0]   disp_q,     disp_d;
  logic [15:0]   ms_count_q, ms_count_d;
  logic [15:0]   ms_cmp_q,   ms_cmp_d;
  logic [4:0]    status_q,   status_d;
  logic [4:0]    irq_mask_q, irq_mask_d;
  logic [PW-1:0] presc_q,    presc_d;
  logic [15:0]   data_out_q, data_out_d;
  logic          irq_q,      irq_d;
  logic [3:0]    btn_meta_q, btn_sync_q, btn_prev_q;

  logic        hit_s;
  logic        wr_s;
  logic        wr_led_s, wr_disp_s, wr_count_s, wr_cmp_s, wr_status_s, wr_mask_s;
  logic        tick_s;
  logic        match_set_s;
  logic [3:0]  btn_rise_s;
  logic [4:0]  w1c_s;
  logic [15:0] rdata_s;

  assign hit_s      = sel & (address[14:3] == 12'd0);
  assign wr_s       = hit_s & we;
  assign tick_s     = (presc_q == PRESC_LAST);
  assign btn_rise_s = btn_sync_q & ~btn_prev_q;

  // Write strobe decode per register
  always_comb begin
    wr_led_s    = 1'b0;
    wr_disp_s   = 1'b0;
    wr_count_s  = 1'b0;
    wr_cmp_s    = 1'b0;
    wr_status_s = 1'b0;
    wr_mask_s   = 1'b0;
    if (wr_s) begin
      case (address[2:0])
        A_LED:     wr_led_s    = 1'b1;
        A_DISPLAY: wr_disp_s   = 1'b1;
        A_COUNT:   wr_count_s  = 1'b1;
        A_COMPARE: wr_cmp_s    = 1'b1;
        A_STATUS:  wr_status_s = 1'b1;
        A_MASK:    wr_mask_s   = 1'b1;
        default:   wr_led_s    = 1'b0;
      endcase
    end else begin
      wr_led_s = 1'b0;
    end
  end

  // Read mux sampled from current register state (read-first)
  always_comb begin
    rdata_s = 16'h0000;
    case (address[2:0])
      A_LED:     rdata_s = {12'h000, led_q};
      A_DISPLAY: rdata_s = disp_q;
      A_COUNT:   rdata_s = ms_count_q;
      A_COMPARE: rdata_s = ms_cmp_q;
      A_STATUS:  rdata_s = {11'h000, status_q};
      A_BUTTONS: rdata_s = {12'h000, btn_sync_q};
      A_MASK:    rdata_s = {11'h000, irq_mask_q};
      default:   rdata_s = 16'h0000;
    endcase
  end

  // Next-state for registers, prescaler, flags and outputs
  always_comb begin
    led_d      = wr_led_s  ? data_in[3:0] : led_q;
    disp_d     = wr_disp_s ? data_in      : disp_q;
    ms_cmp_d   = wr_cmp_s  ? data_in      : ms_cmp_q;
    irq_mask_d = wr_mask_s ? data_in[4:0] : irq_mask_q;

    // A CPU write to the counter beats a tick and restarts the millisecond.
    if (wr_count_s) begin
      ms_count_d = data_in;
      presc_d    = PRESC_ZERO;
    end else if (tick_s) begin
      ms_count_d = ms_count_q + 16'd1;
      presc_d    = PRESC_ZERO;
    end else begin
      ms_count_d = ms_count_q;
      presc_d    = presc_q + PRESC_ONE;
    end

    match_set_s = (wr_count_s | tick_s) & (ms_count_d == ms_cmp_d);
    w1c_s       = wr_status_s ? data_in[4:0] : 5'd0;
    status_d    = (status_q & ~w1c_s) | {btn_rise_s, match_set_s};
    irq_d       = |(status_d & irq_mask_d);
    data_out_d  = hit_s ? rdata_s : 16'h0000;
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      led_q      <= 4'h0;
      disp_q     <= 16'h0000;
      ms_count_q <= 16'h0000;
      ms_cmp_q   <= 16'h0000;
      status_q   <= 5'd0;
      irq_mask_q <= 5'd0;
      presc_q    <= PRESC_ZERO;
      data_out_q <= 16'h0000;
      irq_q      <= 1'b0;
      btn_meta_q <= 4'h0;
      btn_sync_q <= 4'h0;
      btn_prev_q <= 4'h0;
    end else begin
      led_q      <= led_d;
      disp_q     <= disp_d;
      ms_count_q <= ms_count_d;
      ms_cmp_q   <= ms_cmp_d;
      status_q   <= status_d;
      irq_mask_q <= irq_mask_d;
      presc_q    <= presc_d;
      data_out_q <= data_out_d;
      irq_q      <= irq_d;
      btn_meta_q <= btn;
      btn_sync_q <= btn_meta_q;
      btn_prev_q <= btn_sync_q;
    end
  end

  assign data_out      = data_out_q;
  assign leds          = led_q;
  assign display_value = disp_q;
  assign irq           = irq_q;

endmodule

// File: tb/tb_mmio_port.sv
// Directed self-checking bench for mmio_port with a 4-cycle millisecond.
module tb_mmio_port;

  logic        clk;
  logic        reset_n;
  logic        sel;
  logic [14:0] address;
  logic [15:0] data_in;
  logic        we;
  logic [15:0] data_out;
  logic [3:0]  leds;
  logic [15:0] display_value;
  logic [3:0]  btn;
  logic        irq;

  int unsigned total_cnt;
  int unsigned bad_cnt;
  logic [15:0] q;

  mmio_port #(.CYCLES_PER_MS(4)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .sel           (sel),
    .address       (address),
    .data_in       (data_in),
    .we            (we),
    .data_out      (data_out),
    .leds          (leds),
    .display_value (display_value),
    .btn           (btn),
    .irq           (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // One bus cycle; q captures data_out just after the edge.
  task automatic bus(input logic s, input logic w, input logic [14:0] a,
                     input logic [15:0] d, output logic [15:0] dout);
    sel = s; we = w; address = a; data_in = d;
    @(posedge clk); #1;
    dout = data_out;
    sel = 1'b0; we = 1'b0; address = 15'd0; data_in = 16'h0000;
  endtask

  task automatic rd(input logic [14:0] a, output logic [15:0] dout);
    bus(1'b1, 1'b0, a, 16'h0000, dout);
  endtask

  task automatic wr(input logic [14:0] a, input logic [15:0] d);
    logic [15:0] dummy;
    bus(1'b1, 1'b1, a, d, dummy);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    sel = 1'b0; we = 1'b0; address = 15'd0; data_in = 16'h0000; btn = 4'h0;
    #20;
    reset_n = 1'b1;
  endtask

  initial begin
    total_cnt = 0;
    bad_cnt   = 0;
    reset_n   = 1'b0;
    #1;
    do_reset();
    idle(1);

    for (int i = 0; i < 8; i++) begin
      rd(15'(i), q);
      check_val($sformatf("rst_rd%0d", i), q, 16'h0000);
    end
    check_val("rst_leds", {12'h000, leds}, 16'h0000);
    check_val("rst_disp", display_value, 16'h0000);
    check_val("rst_irq", {15'd0, irq}, 16'h0000);

    // read-first write, then read back
    bus(1'b1, 1'b1, 15'd1, 16'hBEEF, q);
    check_val("wr_old", q, 16'h0000);
    check_val("wr_disp", display_value, 16'hBEEF);
    rd(15'd1, q);
    check_val("rd_disp", q, 16'hBEEF);
    bus(1'b0, 1'b1, 15'd1, 16'h5555, q);
    check_val("nosel_dout", q, 16'h0000);
    check_val("nosel_disp", display_value, 16'hBEEF);
    bus(1'b0, 1'b0, 15'd1, 16'h0000, q);
    check_val("nosel_rd", q, 16'h0000);

    wr(15'd0, 16'hFFFF);
    check_val("led_out", {12'h000, leds}, 16'h000F);
    rd(15'd0, q);
    check_val("led_rd", q, 16'h000F);
    wr(15'd6, 16'hFFFF);
    rd(15'd6, q);
    check_val("mask_rd", q, 16'h001F);
    wr(15'd6, 16'h0000);

    // decode misses and reserved slot
    wr(15'd9, 16'h1234);
    wr(15'd7, 16'h1234);
    rd(15'd9, q);
    check_val("miss_rd9", q, 16'h0000);
    rd(15'd7, q);
    check_val("miss_rd7", q, 16'h0000);
    rd(15'd1, q);
    check_val("miss_disp", q, 16'hBEEF);
    check_val("miss_leds", {12'h000, leds}, 16'h000F);

    // millisecond counter wrap and compare
    do_reset();
    idle(1);
    wr(15'd3, 16'h0000);
    wr(15'd6, 16'h0001);
    wr(15'd2, 16'hFFFE);
    rd(15'd2, q);
    check_val("ms_w1", q, 16'hFFFE);
    idle(2);
    rd(15'd2, q);
    check_val("ms_w4", q, 16'hFFFE);
    rd(15'd2, q);
    check_val("ms_w5", q, 16'hFFFF);
    idle(2);
    check_val("ms_irq_pre", {15'd0, irq}, 16'h0000);
    idle(1);
    check_val("ms_irq_set", {15'd0, irq}, 16'h0001);
    rd(15'd2, q);
    check_val("ms_wrap", q, 16'h0000);
    rd(15'd4, q);
    check_val("ms_status", q, 16'h0001);
    wr(15'd4, 16'h0001);
    check_val("ms_irq_clr", {15'd0, irq}, 16'h0000);
    rd(15'd4, q);
    check_val("ms_status_clr", q, 16'h0000);

    // button edge detect
    do_reset();
    idle(1);
    wr(15'd6, 16'h001E);
    btn = 4'b0100;
    idle(2);
    check_val("btn_irq_e2", {15'd0, irq}, 16'h0000);
    idle(1);
    check_val("btn_irq_e3", {15'd0, irq}, 16'h0001);
    rd(15'd4, q);
    check_val("btn_status", q, 16'h0008);
    rd(15'd5, q);
    check_val("btn_level", q, 16'h0004);
    idle(4);
    rd(15'd4, q);
    check_val("btn_hold", q, 16'h0008);
    wr(15'd4, 16'h0008);
    rd(15'd4, q);
    check_val("btn_noretrig", q, 16'h0000);
    check_val("btn_irq_clr", {15'd0, irq}, 16'h0000);
    btn = 4'b0000;
    idle(4);
    btn = 4'b0100;
    idle(2);
    wr(15'd4, 16'h0008);
    rd(15'd4, q);
    check_val("btn_set_wins", q, 16'h0008);

    // asynchronous reset mid-count
    wr(15'd0, 16'h0005);
    wr(15'd3, 16'h0005);
    wr(15'd6, 16'h0001);
    wr(15'd2, 16'h0005);
    check_val("arst_irq_pre", {15'd0, irq}, 16'h0001);
    #2 reset_n = 1'b0;
    #1;
    check_val("arst_irq", {15'd0, irq}, 16'h0000);
    check_val("arst_leds", {12'h000, leds}, 16'h0000);
    #1 reset_n = 1'b1;
    btn = 4'b0000;
    rd(15'd2, q);
    check_val("arst_count", q, 16'h0000);
    rd(15'd4, q);
    check_val("arst_status", q, 16'h0000);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
